// File: rtl/dmem_backend_pkg.sv
// dmem_backend_pkg -- shared constants for the data-memory backend.
//   Width macros:
//     DMEM_BLOCK_ADDR_SIZE : width of the block address bus (default 8)
//     DBLOCK_SIZE_BITS     : width of one data block (default 64)
//   Package contents:
//     CNT_W        : width of the latency counters (latencies 1..15)
//     dmem_state_e : backend FSM state encoding
`ifndef DMEM_BLOCK_ADDR_SIZE
`define DMEM_BLOCK_ADDR_SIZE 8
`endif
`ifndef DBLOCK_SIZE_BITS
`define DBLOCK_SIZE_BITS 64
`endif

package dmem_backend_pkg;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    RDONE = 3'd3,
    WDONE = 3'd4
  } dmem_state_e;
endpackage

// File: rtl/dmem_latency_counter.sv
// dmem_latency_counter -- 4-bit up counter with a terminal-count compare.
//   clock       : rising-edge clock
//   reset       : asynchronous active-low reset (count -> 0)
//   clear       : synchronous clear, has priority over enable
//   enable      : count up by one
//   terminal    : value compared against the current count
//   count       : current count
//   at_terminal : high while count == terminal
module dmem_latency_counter
  import dmem_backend_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] terminal,
  output logic [CNT_W-1:0] count,
  output logic             at_terminal
);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign at_terminal = (count == terminal);
endmodule

// File: rtl/dmem_backend.sv
// dmem_backend -- fixed-latency block memory backend behind a cache.
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   memRen, memWen      : read / write requests
//   BlockAddr, memDin   : request address and write data (latched on accept)
//   memDout             : registered read data, held until the next read ends
//   memReadReady        : one-cycle pulse, memDout valid
//   memWriteDone        : one-cycle pulse, write complete (or posted)
//   dbg_state/dbg_count : FSM state and main latency count for observation
// Optional build macro: DMEM_WRITE_BUFFER_EN adds a one-entry posted write
// buffer that acknowledges a write in one cycle and drains it in background.
//
// Handshake: a requester raises memRen or memWen with a stable address/data
// and holds it until the matching pulse. A request is accepted only on a
// rising edge seen in IDLE (write wins over read); once accepted, the
// operation always completes regardless of the request level, and a request
// still high after the pulse starts a new operation.
`ifndef DMEM_BLOCK_ADDR_SIZE
`define DMEM_BLOCK_ADDR_SIZE 8
`endif
`ifndef DBLOCK_SIZE_BITS
`define DBLOCK_SIZE_BITS 64
`endif

module dmem_backend
  import dmem_backend_pkg::*;
#(
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4,
  parameter int NUM_BLOCKS    = 2**`DMEM_BLOCK_ADDR_SIZE
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            memRen,
  input  logic                            memWen,
  input  logic [`DMEM_BLOCK_ADDR_SIZE-1:0] BlockAddr,
  input  logic [`DBLOCK_SIZE_BITS-1:0]    memDin,
  output logic [`DBLOCK_SIZE_BITS-1:0]    memDout,
  output logic                            memReadReady,
  output logic                            memWriteDone,
  output logic [2:0]                      dbg_state,
  output logic [CNT_W-1:0]                dbg_count
);
  localparam int W     = `DBLOCK_SIZE_BITS;
  localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [CNT_W-1:0] RD_TERM = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_TERM = CNT_W'(WRITE_LATENCY - 1);

  dmem_state_e      state;
  logic [IDX_W-1:0] addr_q;
  logic [IDX_W-1:0] idx_in;
  logic [W-1:0]     mem [NUM_BLOCKS];
  logic [W-1:0]     rd_data;
  logic             wr_take;
  logic             mem_we;
  logic [IDX_W-1:0] mem_wa;
  logic [W-1:0]     mem_wd;
  logic [CNT_W-1:0] cnt;
  logic             cnt_done;

  // Addresses wrap modulo the storage depth.
  assign idx_in    = IDX_W'(BlockAddr);
  assign dbg_state = state;
  assign dbg_count = cnt;

  // The counter sits at 0 in IDLE so the first busy cycle sees count 0;
  // leaving on count == LATENCY-1 gives exactly LATENCY edges to the pulse.
  dmem_latency_counter u_lat (
    .clock       (clock),
    .reset       (reset),
    .clear       (state == IDLE),
    .enable      ((state == READ) || (state == WRITE)),
    .terminal    ((state == READ) ? RD_TERM : WR_TERM),
    .count       (cnt),
    .at_terminal (cnt_done)
  );

`ifdef DMEM_WRITE_BUFFER_EN
  logic             buf_valid;
  logic [IDX_W-1:0] buf_addr;
  logic [W-1:0]     buf_data;
  logic [CNT_W-1:0] drain_cnt;
  logic             drain_done;

  // A write is only taken when the buffer is free; otherwise it waits.
  assign wr_take = memWen && !buf_valid;

  dmem_latency_counter u_drain (
    .clock       (clock),
    .reset       (reset),
    .clear       (!buf_valid),
    .enable      (buf_valid),
    .terminal    (WR_TERM),
    .count       (drain_cnt),
    .at_terminal (drain_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if ((state == IDLE) && wr_take) begin
      buf_valid <= 1'b1;
      buf_addr  <= idx_in;
      buf_data  <= memDin;
    end else if (buf_valid && drain_done) begin
      buf_valid <= 1'b0;
    end
  end

  // A read hitting the pending entry must see the posted data.
  assign rd_data = (buf_valid && (buf_addr == addr_q)) ? buf_data : mem[addr_q];
  assign mem_we  = buf_valid && drain_done;
  assign mem_wa  = buf_addr;
  assign mem_wd  = buf_data;
`else
  logic [W-1:0] data_q;

  assign wr_take = memWen;
  assign rd_data = mem[addr_q];
  assign mem_we  = (state == WRITE) && cnt_done;
  assign mem_wa  = addr_q;
  assign mem_wd  = data_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else if ((state == IDLE) && memWen) begin
      data_q <= memDin;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      memDout      <= '0;
      memReadReady <= 1'b0;
      memWriteDone <= 1'b0;
    end else begin
      memReadReady <= 1'b0;
      memWriteDone <= 1'b0;
      case (state)
        IDLE: begin
          if (memWen) begin
            // A blocked write also blocks reads: write keeps priority.
            if (wr_take) begin
`ifdef DMEM_WRITE_BUFFER_EN
              state        <= WDONE;
              memWriteDone <= 1'b1;
`else
              addr_q <= idx_in;
              state  <= WRITE;
`endif
            end
          end else if (memRen) begin
            addr_q <= idx_in;
            state  <= READ;
          end
        end
        READ: begin
          if (cnt_done) begin
            state        <= RDONE;
            memReadReady <= 1'b1;
            memDout      <= rd_data;
          end
        end
        WRITE: begin
          if (cnt_done) begin
            state        <= WDONE;
            memWriteDone <= 1'b1;
          end
        end
        RDONE:   state <= IDLE;
        WDONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset; an aborted operation never writes it.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end
endmodule

// File: tb/tb_dmem_backend.sv
// tb_dmem_backend -- directed and random checks of dmem_backend against a
// simple array model of block storage and request/pulse timing.
`ifndef DMEM_BLOCK_ADDR_SIZE
`define DMEM_BLOCK_ADDR_SIZE 8
`endif
`ifndef DBLOCK_SIZE_BITS
`define DBLOCK_SIZE_BITS 64
`endif

module tb_dmem_backend;
  import dmem_backend_pkg::*;

  localparam int AW      = `DMEM_BLOCK_ADDR_SIZE;
  localparam int W       = `DBLOCK_SIZE_BITS;
  localparam int RL      = 4;
  localparam int WL      = 4;
  localparam int NB      = 64;
  localparam int TIMEOUT = 60;
`ifdef DMEM_WRITE_BUFFER_EN
  localparam int WR_DONE_LAT = 1;
`else
  localparam int WR_DONE_LAT = WL;
`endif

  logic             clock;
  logic             reset;
  logic             memRen;
  logic             memWen;
  logic [AW-1:0]    BlockAddr;
  logic [W-1:0]     memDin;
  logic [W-1:0]     memDout;
  logic             memReadReady;
  logic             memWriteDone;
  logic [2:0]       dbg_state;
  logic [CNT_W-1:0] dbg_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int drain_end = -100;

  logic [W-1:0]  model_mem [NB];
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  last_rd;
  logic [AW-1:0] wr_addrs[$];

  dmem_backend #(
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL),
    .NUM_BLOCKS    (NB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .memRen       (memRen),
    .memWen       (memWen),
    .BlockAddr    (BlockAddr),
    .memDin       (memDin),
    .memDout      (memDout),
    .memReadReady (memReadReady),
    .memWriteDone (memWriteDone),
    .dbg_state    (dbg_state),
    .dbg_count    (dbg_count)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_block();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i += 32) v = (v << 32) | W'($urandom);
    return v;
  endfunction

  function automatic int idx(input logic [AW-1:0] a);
    return int'(a) % NB;
  endfunction

  // Waits for the read or write pulse; n = negedges seen since the request
  // was raised (1 = the negedge right after the acceptance edge).
  task automatic wait_pulse(input bit is_read, input int drop_at, input bit scramble, output int n);
    n = 0;
    forever begin
      @(negedge clock);
      n++;
      if (n == drop_at) begin
        if (is_read) memRen = 1'b0;
        else memWen = 1'b0;
      end
      if (scramble && n == 1) begin
        BlockAddr = AW'($urandom);
        memDin    = rand_block();
      end
      if ((is_read ? memReadReady : memWriteDone) === 1'b1) break;
      if (n >= TIMEOUT) break;
    end
    checks++;
    assert (n < TIMEOUT) else begin
      errors++;
      $error("FAIL pulse_timeout: observed=%0d cycles expected<%0d", n, TIMEOUT);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [AW-1:0] addr, input logic [W-1:0] data, input bit scramble);
    int n;
    int c0;
    int a;
    c0 = cyc + 1;
    a  = c0;
`ifdef DMEM_WRITE_BUFFER_EN
    if (drain_end + 1 > a) a = drain_end + 1;
`endif
    memWen    = 1'b1;
    BlockAddr = addr;
    memDin    = data;
    wait_pulse(1'b0, 0, scramble && (a == c0), n);
    check("wr_done_latency", W'(n), W'(a + WR_DONE_LAT - c0 + 1));
    model_mem[idx(addr)] = data;
`ifdef DMEM_WRITE_BUFFER_EN
    drain_end = a + WL;
`endif
    memWen = 1'b0;
    @(negedge clock);
    check("wr_done_width", W'(memWriteDone), '0);
    check("wr_back_idle", W'(dbg_state), W'(IDLE));
    check("dout_hold", memDout, last_rd);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int drop_at, input bit scramble);
    int n;
    logic [W-1:0] exp;
    memRen    = 1'b1;
    BlockAddr = addr;
    exp_q.push_back(model_mem[idx(addr)]);
    wait_pulse(1'b1, drop_at, scramble, n);
    check("rd_latency", W'(n), W'(RL + 1));
    exp = exp_q.pop_front();
    check("rd_data", memDout, exp);
    last_rd = exp;
    memRen  = 1'b0;
    @(negedge clock);
    check("rd_ready_width", W'(memReadReady), '0);
    check("rd_dout_held", memDout, last_rd);
    check("rd_back_idle", W'(dbg_state), W'(IDLE));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    bit seen;
    logic [W-1:0] old_d;
    logic [W-1:0] a5;
    logic [W-1:0] d;
    logic [AW-1:0] ra;

    memRen = 1'b0; memWen = 1'b0; BlockAddr = '0; memDin = '0;
    last_rd = '0;
    reset = 1'b0;
    #1;
    check("reset_ready", W'(memReadReady), '0);
    check("reset_done", W'(memWriteDone), '0);
    check("reset_dout", memDout, '0);
    check("reset_state", W'(dbg_state), W'(IDLE));
    check("reset_count", W'(dbg_count), '0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Basic write then read of 0x05.
    a5 = {(W/8){8'hA5}};
    do_write(8'h05, a5, 1'b1);
    wr_addrs.push_back(8'h05);
    do_read(8'h05, 0, 1'b1);

    // Both requests at once: write first, read sees new data.
    d = rand_block();
    memRen = 1'b1;
    BlockAddr = 8'h07;
    do_write(8'h07, d, 1'b0);
    wr_addrs.push_back(8'h07);
    do_read(8'h07, 0, 1'b0);

    // Write then immediate read of the same block.
    do_write(8'h02, {(W/8){8'h11}}, 1'b0);
    wr_addrs.push_back(8'h02);
    do_read(8'h02, 0, 1'b0);

    // Read request dropped one cycle after acceptance.
    do_read(8'h05, 2, 1'b0);

    // Address wrap and top index.
    do_write(8'h45, rand_block(), 1'b0);
    do_read(8'h05, 0, 1'b0);
    do_write(8'h3F, rand_block(), 1'b0);
    wr_addrs.push_back(8'h3F);
    do_read(8'hFF, 0, 1'b0);

    // Request held across the pulse starts a second read right away.
    memRen = 1'b1;
    BlockAddr = 8'h07;
    wait_pulse(1'b1, 0, 1'b0, n);
    check("b2b_first_latency", W'(n), W'(RL + 1));
    check("b2b_first_data", memDout, model_mem[idx(8'h07)]);
    wait_pulse(1'b1, 0, 1'b0, n);
    check("b2b_second_latency", W'(n), W'(RL + 2));
    check("b2b_second_data", memDout, model_mem[idx(8'h07)]);
    last_rd = model_mem[idx(8'h07)];
    memRen = 1'b0;
    @(negedge clock);

    // Reset two cycles into a write: operation discarded, array kept.
    old_d = rand_block();
    do_write(8'h09, old_d, 1'b0);
    wr_addrs.push_back(8'h09);
    repeat (WL + 2) @(negedge clock);
    memWen = 1'b1;
    BlockAddr = 8'h09;
    memDin = {(W/8){8'h3C}};
    repeat (2) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_done", W'(memWriteDone), '0);
    check("midrst_ready", W'(memReadReady), '0);
    check("midrst_dout", memDout, '0);
    check("midrst_state", W'(dbg_state), W'(IDLE));
    check("midrst_count", W'(dbg_count), '0);
    memWen = 1'b0;
    last_rd = '0;
    drain_end = -100;
    @(negedge clock);
    reset = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (memWriteDone === 1'b1 || memReadReady === 1'b1) seen = 1'b1;
    end
    check("midrst_no_pulse", W'(seen), '0);
    do_read(8'h09, 0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 30; i++) begin
      if (wr_addrs.size() == 0 || $urandom_range(0, 1) == 1) begin
        ra = AW'($urandom_range(0, (1 << AW) - 1));
        do_write(ra, rand_block(), 1'b1);
        wr_addrs.push_back(ra);
      end else begin
        ra = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
        do_read(ra, ($urandom_range(0, 1) == 1) ? 2 : 0, 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
